// File: rtl/video_pointer_ctrl.sv
// video_pointer_ctrl
// Hardware mouse-pointer overlay. A 32x32 sprite is placed at (pos_x, pos_y)
// in beam coordinates. Each beam pixel is tested against the sprite window,
// and the matching sprite word is fetched from an external synchronous-read
// RAM. The result is presented to the compositor two cycles after the pixel
// coordinates. A small CPU port gives access to the position and control
// registers and posts writes into the sprite RAM. Sprite writes share the RAM
// port with the video fetch, and the video fetch always wins.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   x, y, visible         beam position and active-area flag
//   cpu_sel/we/addr/wdata CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack    read data and one-cycle completion pulse
//   spr_addr/we/wdata     sprite RAM port (address/strobe/data)
//   spr_rdata             sprite RAM read data, one cycle after spr_addr
//   pointer_r/g/b/opaque  pointer pixel to the compositor
module video_pointer_ctrl #(
    parameter int SPR_W = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      x,
    input  logic [15:0]      y,
    input  logic             visible,
    input  logic             cpu_sel,
    input  logic             cpu_we,
    input  logic [11:0]      cpu_addr,
    input  logic [15:0]      cpu_wdata,
    output logic [15:0]      cpu_rdata,
    output logic             cpu_ack,
    output logic [9:0]       spr_addr,
    output logic             spr_we,
    output logic [SPR_W-1:0] spr_wdata,
    input  logic [SPR_W-1:0] spr_rdata,
    output logic [3:0]       pointer_r,
    output logic [3:0]       pointer_g,
    output logic [3:0]       pointer_b,
    output logic             pointer_opaque
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2,
        WAIT = 2'd3
    } cpu_state_t;

    cpu_state_t state, state_nxt;

    logic [15:0]      pos_x;
    logic [15:0]      pos_y;
    logic             enable;
    logic [9:0]       pend_addr;
    logic [SPR_W-1:0] pend_data;

    logic [15:0] dx_p0;
    logic [15:0] dy_p0;
    logic        hit_p0;
    logic        hit_p1;
    logic        hit_p2;

    logic        accept_imm;
    logic        accept_wr;
    logic        reg_wr;
    logic        reg_rd;
    logic        wr_issue;
    logic [15:0] reg_rval;
    logic        unused_addr_bit;

    assign unused_addr_bit = cpu_addr[10];

    // Stage 0: window test on the incoming pixel. Modulo-2^16 subtraction makes
    // a sprite hanging off the left/top edge (pos near 0xFFFF) wrap naturally.
    assign dx_p0  = x - pos_x;
    assign dy_p0  = y - pos_y;
    assign hit_p0 = enable & visible & (dx_p0 < 16'd32) & (dy_p0 < 16'd32);

    // CPU request decode; only meaningful while IDLE.
    assign accept_imm = (state == IDLE) & cpu_sel & (~cpu_addr[11] | ~cpu_we);
    assign accept_wr  = (state == IDLE) & cpu_sel & cpu_we & cpu_addr[11];
    assign reg_wr     = accept_imm & cpu_we & ~cpu_addr[11];
    assign reg_rd     = accept_imm & ~cpu_we & ~cpu_addr[11];

    // A posted sprite write takes the RAM port only in a cycle the video side
    // leaves free. spr_we doubles as the "already issued" marker, so a write
    // issues exactly once.
    assign wr_issue = (state == PEND) & ~spr_we & ~hit_p0;

    always_comb begin
        reg_rval = 16'h0000;
        case (cpu_addr[1:0])
            2'd0: reg_rval = pos_x;
            2'd1: reg_rval = pos_y;
            2'd2: reg_rval = {15'h0000, enable};
            2'd3: reg_rval = {14'h0000, (state == PEND), hit_p1};
            default: reg_rval = 16'h0000;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_wr) begin
                    state_nxt = PEND;
                end else if (accept_imm) begin
                    state_nxt = ACK;
                end
            end
            PEND: begin
                if (spr_we) begin
                    state_nxt = ACK;
                end
            end
            ACK:  state_nxt = WAIT;
            WAIT: begin
                if (!cpu_sel) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cpu_ack = (state == ACK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pos_x     <= '0;
            pos_y     <= '0;
            enable    <= 1'b0;
            hit_p1    <= 1'b0;
            hit_p2    <= 1'b0;
            spr_we    <= 1'b0;
            spr_addr  <= '0;
            spr_wdata <= '0;
            cpu_rdata <= '0;
        end else begin
            state <= state_nxt;

            // Stage 1: hit registered, RAM address presented (video or CPU write).
            hit_p1 <= hit_p0;
            spr_we <= wr_issue;
            if (hit_p0) begin
                spr_addr <= {dy_p0[4:0], dx_p0[4:0]};
            end else if (wr_issue) begin
                spr_addr <= pend_addr;
            end else begin
                spr_addr <= '0;
            end
            spr_wdata <= wr_issue ? pend_data : '0;

            // Stage 2: hit aligned with the RAM read data.
            hit_p2 <= hit_p1;

            // Read data exists only in the ACK cycle; sprite reads return zero.
            cpu_rdata <= reg_rd ? reg_rval : 16'h0000;

            if (reg_wr) begin
                case (cpu_addr[1:0])
                    2'd0: pos_x  <= cpu_wdata;
                    2'd1: pos_y  <= cpu_wdata;
                    2'd2: enable <= cpu_wdata[0];
                    default: ;
                endcase
            end
        end
    end

    // Posted-write holding registers; only read while PEND, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept_wr) begin
            pend_addr <= cpu_addr[9:0];
            pend_data <= cpu_wdata[SPR_W-1:0];
        end
    end

    // The RAM returns data one cycle after the stage-1 address, so the pixel
    // is gated by the stage-2 hit rather than registered again; this keeps the
    // pixel-to-pointer latency at two cycles.
    assign pointer_opaque = hit_p2 & spr_rdata[12];
    assign pointer_r      = hit_p2 ? spr_rdata[11:8] : 4'h0;
    assign pointer_g      = hit_p2 ? spr_rdata[7:4]  : 4'h0;
    assign pointer_b      = hit_p2 ? spr_rdata[3:0]  : 4'h0;

endmodule

// File: tb/tb_video_pointer_ctrl.sv
// Self-checking bench for video_pointer_ctrl with a behavioural sprite RAM.
module tb_video_pointer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] x, y;
    logic        visible;
    logic        cpu_sel, cpu_we;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic [9:0]  spr_addr;
    logic        spr_we;
    logic [12:0] spr_wdata;
    logic [12:0] spr_rdata;
    logic [3:0]  pointer_r, pointer_g, pointer_b;
    logic        pointer_opaque;

    int checks = 0;
    int errors = 0;

    // Reference state: what software believes it has programmed.
    logic [15:0] m_px, m_py;
    logic        m_en;
    logic [12:0] m_ram [1024];

    // Sprite RAM: synchronous read, one cycle latency.
    logic [12:0] ram [1024];

    video_pointer_ctrl #(.SPR_W(13)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .visible(visible),
        .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .spr_addr(spr_addr), .spr_we(spr_we), .spr_wdata(spr_wdata),
        .spr_rdata(spr_rdata), .pointer_r(pointer_r), .pointer_g(pointer_g),
        .pointer_b(pointer_b), .pointer_opaque(pointer_opaque)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (spr_we) ram[spr_addr] <= spr_wdata;
        spr_rdata <= ram[spr_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] ptr_now();
        return {pointer_opaque, pointer_r, pointer_g, pointer_b};
    endfunction

    function automatic logic [31:0] all_outs();
        return {3'b0, cpu_ack, spr_we, spr_addr, spr_wdata, pointer_opaque, pointer_r, pointer_g, pointer_b}
               | {16'h0, cpu_rdata};
    endfunction

    // Distance from sprite origin to pixel, modulo the 16-bit coordinate space.
    function automatic int wrap_dist(input logic [15:0] p, input logic [15:0] o);
        return (int'(p) - int'(o) + 65536) % 65536;
    endfunction

    task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
        int n = 0;
        cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        do begin tick(); n++; end while (!cpu_ack && n < 100);
        chk("write_ack", cpu_ack, 1);
        cpu_sel = 1'b0; cpu_we = 1'b0;
        tick(); tick();
        if (a[11]) m_ram[a[9:0]] = d[12:0];
        else if (a[1:0] == 2'd0) m_px = d;
        else if (a[1:0] == 2'd1) m_py = d;
        else if (a[1:0] == 2'd2) m_en = d[0];
    endtask

    task automatic cpu_read(input string tag, input logic [11:0] a, input logic [15:0] exp);
        int n = 0;
        cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        do begin tick(); n++; end while (!cpu_ack && n < 100);
        chk({tag, "_ack"}, cpu_ack, 1);
        chk(tag, cpu_rdata, exp);
        cpu_sel = 1'b0;
        tick();
        chk({tag, "_rdata_idle"}, cpu_rdata, 0);
        tick();
    endtask

    // Random pixels around (bx, by); the model predicts address and pixel.
    task automatic sweep(input string tag, input int n, input int bx, input int by);
        logic [12:0] prev = 13'h0;
        for (int i = 0; i < n; i++) begin
            logic [15:0] px, py;
            logic pv, h;
            int ddx, ddy;
            logic [12:0] e;
            px = 16'(bx - 8 + int'($urandom_range(0, 47)));
            py = 16'(by - 8 + int'($urandom_range(0, 47)));
            pv = ($urandom_range(0, 3) != 0);
            ddx = wrap_dist(px, m_px);
            ddy = wrap_dist(py, m_py);
            h = m_en && pv && ddx < 32 && ddy < 32;
            e = h ? m_ram[ddy * 32 + ddx] : 13'h0;
            x = px; y = py; visible = pv;
            tick();
            if (h) chk({tag, "_addr"}, spr_addr, ddy * 32 + ddx);
            chk({tag, "_we"}, spr_we, 0);
            chk({tag, "_ptr"}, ptr_now(), prev);
            prev = e;
        end
        visible = 1'b0;
        tick();
        chk({tag, "_ptr_tail"}, ptr_now(), prev);
        tick();
    endtask

    initial begin
        logic [15:0] wd;
        int n;
        reset = 1'b1; x = 0; y = 0; visible = 0;
        cpu_sel = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        m_px = 0; m_py = 0; m_en = 0;
        #1;
        chk("reset_outputs", all_outs(), 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("after_reset_outputs", all_outs(), 0);

        for (int r = 0; r < 4; r++) cpu_read("reset_reg", 12'(r), 16'h0);

        // Fill the whole sprite through the posted-write path.
        for (int a = 0; a < 1024; a++) cpu_write(12'h800 | 12'(a), 16'($urandom()));

        cpu_write(12'h000, 16'd100);
        cpu_write(12'h001, 16'd50);
        cpu_write(12'h002, 16'hFFFF);
        cpu_read("rd_pos_x", 12'h000, 16'd100);
        cpu_read("rd_pos_y", 12'h001, 16'd50);
        cpu_read("rd_ctrl", 12'h002, 16'h0001);
        cpu_write(12'h800 | 12'h0A2, 16'h1ABC);

        // Basic fetch: pixel (102,55) -> word {5,2}.
        x = 102; y = 55; visible = 1;
        tick();
        chk("basic_addr", spr_addr, 10'h0A2);
        chk("basic_we", spr_we, 0);
        visible = 0;
        tick();
        chk("basic_ptr", ptr_now(), 13'h1ABC);
        tick();
        chk("basic_ptr_off", ptr_now(), 0);

        sweep("sweep", 300, 100, 50);

        // Posted write held off by a full line of 32 hits.
        wd = 16'($urandom());
        cpu_sel = 1; cpu_we = 1; cpu_addr = 12'hBFF; cpu_wdata = wd;
        for (int i = 0; i < 32; i++) begin
            x = 16'(100 + i); y = 50; visible = 1;
            tick();
            chk("hits_no_we", spr_we, 0);
            chk("hits_no_ack", cpu_ack, 0);
        end
        visible = 0;
        tick();
        chk("gap_we", spr_we, 1);
        chk("gap_addr", spr_addr, 10'h3FF);
        chk("gap_wdata", spr_wdata, wd[12:0]);
        chk("gap_no_ack", cpu_ack, 0);
        tick();
        chk("gap_ack", cpu_ack, 1);
        chk("gap_we_once", spr_we, 0);
        cpu_sel = 0; cpu_we = 0;
        m_ram[10'h3FF] = wd[12:0];
        tick(); tick();
        cpu_read("status_idle", 12'h003, 16'h0);

        // Reset while a write is pending.
        x = 100; y = 50; visible = 1;
        cpu_sel = 1; cpu_we = 1; cpu_addr = 12'hBFE; cpu_wdata = ~{3'b0, m_ram[10'h3FE]};
        tick(); tick();
        chk("pend_no_we", spr_we, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        cpu_sel = 0; cpu_we = 0; visible = 0;
        tick();
        chk("reset_held_outputs", all_outs(), 0);
        reset = 1'b0;
        m_px = 0; m_py = 0; m_en = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_reset_we", spr_we, 0);
            chk("post_reset_ack", cpu_ack, 0);
        end
        cpu_read("post_reset_reg0", 12'h000, 16'h0);
        cpu_write(12'h000, 16'd100);
        cpu_write(12'h001, 16'd50);
        cpu_write(12'h002, 16'h0001);
        x = 130; y = 81; visible = 1;
        tick();
        chk("discarded_addr", spr_addr, 10'h3FE);
        visible = 0;
        tick();
        chk("discarded_word", ptr_now(), m_ram[10'h3FE]);
        tick();

        // Disable while pixels keep hitting; the hold on cpu_sel must not re-ack.
        x = 102; y = 55; visible = 1;
        tick(); tick();
        cpu_sel = 1; cpu_we = 1; cpu_addr = 12'h002; cpu_wdata = 16'h0000;
        n = 0;
        do begin tick(); n++; end while (!cpu_ack && n < 100);
        chk("dis_ack", cpu_ack, 1);
        chk("dis_ptr_at_ack", ptr_now(), 13'h1ABC);
        m_en = 0;
        tick();
        chk("dis_ptr_old_enable", ptr_now(), 13'h1ABC);
        tick();
        chk("dis_ptr_off", ptr_now(), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_sel_no_ack", cpu_ack, 0);
        end
        cpu_sel = 0; cpu_we = 0;
        tick(); tick();
        for (int i = 0; i < 20; i++) begin
            x = 16'(100 + $urandom_range(0, 31)); y = 16'(50 + $urandom_range(0, 31));
            visible = (i >= 10);
            tick();
            chk("disabled_opaque", pointer_opaque, 0);
        end
        visible = 0;
        tick(); tick();

        // Wrap-around at the left edge.
        cpu_write(12'h002, 16'h0001);
        cpu_write(12'h000, 16'hFFF0);
        cpu_write(12'h001, 16'h0000);
        x = 3; y = 0; visible = 1;
        tick();
        chk("wrap_addr", spr_addr, 10'h013);
        x = 16;
        tick();
        chk("wrap_ptr", ptr_now(), m_ram[10'h013]);
        visible = 0;
        tick();
        chk("wrap_edge_ptr", ptr_now(), 0);
        tick();
        cpu_write(12'h001, 16'hFFF0);
        sweep("wrap_sweep", 200, 16'hFFF0, 16'hFFF0);

        cpu_read("sprite_read", 12'h805, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
